// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the MIPS interlock logic: defaults, register-zero
// encoding, the NOP word consumed by flush/bubble logic and the hazard decode helper.
package hazard_stall_unit_pkg;

    localparam int           MD_LATENCY_DEF = 4;
    localparam int           MD_CNT_W       = 4;
    localparam logic [4:0]   REG_ZERO       = 5'd0;
    localparam logic [31:0]  NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        PIPE_RUN   = 2'd0,
        PIPE_STALL = 2'd1,
        PIPE_FLUSH = 2'd2
    } pipe_action_e;

    // A load into $0 never produces a value, so it cannot create a dependence.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ld_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return mem_read && (ld_rt != REG_ZERO) &&
               ((ld_rt == id_rs) || (id_uses_rt && (ld_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Tracks the multi-cycle multiply/divide unit: loads the latency on issue and
// counts down until HI/LO become readable from ID.
module md_busy_counter
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_issue,
    output logic o_busy
);

    logic [MD_CNT_W-1:0] r_md_cnt;

    // Busy countdown: reset clears, issue reloads, otherwise decrement to zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_md_cnt <= {MD_CNT_W{1'b0}};
        end else if (i_issue) begin
            r_md_cnt <= MD_CNT_W'(MD_LATENCY);
        end else if (r_md_cnt != {MD_CNT_W{1'b0}}) begin
            r_md_cnt <= r_md_cnt - {{(MD_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_md_cnt <= r_md_cnt;
        end
    end

    assign o_busy = (r_md_cnt != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: decides per cycle whether ID advances, stalls or is flushed,
// and keeps a saturating count of stall cycles.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_IsMulDiv,
    input  logic             IF_ID_IsMfHiLo,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic             EX_Mispredict,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCount
);

    logic         w_load_use;
    logic         w_md_haz;
    logic         w_stall;
    logic         w_flush;
    logic         w_issue_md;
    logic         w_md_busy;
    pipe_action_e w_action;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_load_use = load_use_hit(ID_EX_MemRead, ID_EX_RegisterRt,
                                     IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_UsesRt);
    assign w_md_haz   = w_md_busy && (IF_ID_IsMfHiLo || IF_ID_IsMulDiv);
    assign w_flush    = EX_Mispredict;
    assign w_stall    = !EX_Mispredict && (w_load_use || w_md_haz);
    assign w_issue_md = IF_ID_IsMulDiv && !w_stall && !w_flush;

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_issue (w_issue_md),
        .o_busy  (w_md_busy)
    );

    // Pick the pipeline action; flush outranks stall and reset forces free-run enables.
    always_comb begin
        w_action = PIPE_RUN;
        if (Rst) begin
            w_action = PIPE_RUN;
        end else if (w_flush) begin
            w_action = PIPE_FLUSH;
        end else if (w_stall) begin
            w_action = PIPE_STALL;
        end else begin
            w_action = PIPE_RUN;
        end
    end

    // Translate the action into register enables and clear strobes.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        case (w_action)
            PIPE_STALL: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
            PIPE_FLUSH: begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Flush  = 1'b1;
            end
            default: begin
                PCWrite      = 1'b1;
                IF_ID_Write  = 1'b1;
            end
        endcase
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign MdBusy     = w_md_busy;
    assign StallCount = r_stall_cnt;

endmodule
